// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants for the pipelined ID stage: opcodes, instruction
// field positions, the reset PC default and the immediate-extension selector.
package id_stage_pipe_pkg;

  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;

  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RD_LSB  = 11;
  localparam int unsigned FIELD_W = 5;
  localparam int unsigned IMM_W   = 16;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    IMM_SEXT,
    IMM_ZEXT,
    IMM_LUI
  } imm_kind_e;

  // Logical immediates are zero-extended, lui shifts up, everything else sign-extends.
  function automatic imm_kind_e imm_kind(input logic [5:0] opcode);
    imm_kind_e kind;
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI: kind = IMM_ZEXT;
      OP_LUI:                   kind = IMM_LUI;
      default:                  kind = IMM_SEXT;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/id_stage_pipe_regfile.sv
// General register file: two combinational read ports with same-cycle
// write-back bypass; register 0 is hard-wired to zero.
module id_regfile
  import id_stage_pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_NUM = 32,
  localparam int unsigned AW     = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [REG_NUM];
  logic              wr_en;
  logic              bypass_a;
  logic              bypass_b;

  assign wr_en = we_i && (waddr_i != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign bypass_a = wr_en && (waddr_i == raddr_a_i);
  assign bypass_b = wr_en && (waddr_i == raddr_b_i);

  // Bypass wins over the stored value so the consumer sees this cycle's write-back.
  assign rdata_a_o = (raddr_a_i == '0) ? '0 :
                     bypass_a          ? wdata_i :
                                         regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 :
                     bypass_b          ? wdata_i :
                                         regs_q[raddr_b_i];

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined decode stage: IF/ID register with valid/ready handshakes, load-use
// stall, flush, register file read and immediate extension.
// Optional ID_PERF_EN adds perf_stall/perf_issue counters.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_NUM  = 32,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  localparam int unsigned AW      = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_load,
  input  logic [AW-1:0]     ex_dst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic [AW-1:0]     out_rs,
  output logic [AW-1:0]     out_rt,
  output logic [AW-1:0]     out_rd,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [DATA_W-1:0] out_imm
`ifdef ID_PERF_EN
  ,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_issue
`endif
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        stall;
  logic [15:0] imm16;

  assign out_rs = AW'(instr_q[RS_LSB +: FIELD_W]);
  assign out_rt = AW'(instr_q[RT_LSB +: FIELD_W]);
  assign out_rd = AW'(instr_q[RD_LSB +: FIELD_W]);

  assign stall = valid_q && ex_load && (ex_dst != '0) &&
                 ((ex_dst == out_rs) || (ex_dst == out_rt));

  assign out_valid = valid_q && !stall;
  assign in_ready  = flush || !valid_q || (out_ready && !stall);

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      valid_d = 1'b1;
      pc_d    = in_pc;
      instr_d = in_instr;
    end else if (out_valid && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign out_pc    = pc_q;
  assign out_instr = instr_q;

  id_regfile #(
    .DATA_W  (DATA_W),
    .REG_NUM (REG_NUM)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (reset),
    .we_i      (wb_we),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (out_rs),
    .raddr_b_i (out_rt),
    .rdata_a_o (out_rs_data),
    .rdata_b_o (out_rt_data)
  );

  assign imm16 = instr_q[IMM_W-1:0];

  // Size casts of signed operands sign-extend, keeping DATA_W > 32 correct.
  always_comb begin
    out_imm = DATA_W'($signed(imm16));
    case (imm_kind(instr_q[OPC_LSB +: OPC_W]))
      IMM_ZEXT: out_imm = DATA_W'(imm16);
      IMM_LUI:  out_imm = DATA_W'($signed({imm16, 16'h0000}));
      default:  ;
    endcase
  end

`ifdef ID_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_issue_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_issue_q <= '0;
    end else begin
      if (valid_q && stall) perf_stall_q <= perf_stall_q + 32'd1;
      if (out_valid && out_ready) perf_issue_q <= perf_issue_q + 32'd1;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_issue = perf_issue_q;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios plus randomized
// traffic checked against a behavioural model of the decode stage.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_instr;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_load;
  logic [4:0]  ex_dst;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;
  logic [4:0]  out_rs, out_rt, out_rd;
  logic [31:0] out_rs_data, out_rt_data, out_imm;
`ifdef ID_PERF_EN
  logic [31:0] perf_stall, perf_issue;
`endif

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  bit          m_valid;
  logic [31:0] m_pc, m_instr;
  logic [31:0] m_rf [32];
  logic [31:0] m_pstall, m_pissue;

  always #5 clk = ~clk;

  id_stage_pipe #(
    .DATA_W   (32),
    .REG_NUM  (32),
    .RESET_PC (32'h0000_3000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .flush       (flush),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .ex_load     (ex_load),
    .ex_dst      (ex_dst),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_rs      (out_rs),
    .out_rt      (out_rt),
    .out_rd      (out_rd),
    .out_rs_data (out_rs_data),
    .out_rt_data (out_rt_data),
    .out_imm     (out_imm)
`ifdef ID_PERF_EN
    ,
    .perf_stall  (perf_stall),
    .perf_issue  (perf_issue)
`endif
  );

  function automatic logic [31:0] f_imm(input logic [31:0] ins);
    logic [5:0]  op;
    logic [15:0] imm;
    op  = ins[31:26];
    imm = ins[15:0];
    if (op == 6'h0C || op == 6'h0D || op == 6'h0E) return {16'h0000, imm};
    if (op == 6'h0F) return {imm, 16'h0000};
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wb_we && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic bit m_stall();
    return m_valid && ex_load && ex_dst != 5'd0 &&
           (ex_dst == m_instr[25:21] || ex_dst == m_instr[20:16]);
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_pc     = 32'h0000_3000;
    m_instr  = 32'h0;
    m_pstall = 32'h0;
    m_pissue = 32'h0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_pc = 32'h0; in_instr = 32'h0; flush = 1'b0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    ex_load = 1'b0; ex_dst = 5'd0; out_ready = 1'b0;
  endtask

  // One clock edge: the model takes the edge with the inputs currently driven.
  task automatic tick();
    bit st, ov, ir;
    st = m_stall();
    ov = m_valid && !st;
    ir = flush || !m_valid || (out_ready && !st);
    @(posedge clk);
    if (m_valid && st) m_pstall++;
    if (ov && out_ready) m_pissue++;
    if (flush) m_valid = 1'b0;
    else if (in_valid && ir) begin
      m_valid = 1'b1; m_pc = in_pc; m_instr = in_instr;
    end else if (ov && out_ready) m_valid = 1'b0;
    if (wb_we && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
    @(negedge clk);
  endtask

  task automatic load_instr(input logic [31:0] pc, input logic [31:0] ins);
    in_valid = 1'b1; in_pc = pc; in_instr = ins; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] ins;
    idle_inputs();
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    tests++; if (out_pc !== 32'h0000_3000) begin fails++; $display("FAIL reset_out_pc: got %h want 00003000", out_pc); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    tests++; if (out_instr !== 32'h0) begin fails++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
    ins = {6'h00, 5'd7, 5'd9, 5'd1, 11'h021};
    load_instr(32'h0000_3000, ins);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL accept_latency: out_valid got %0b want 1", out_valid); end
    tests++; if (out_rs_data !== 32'h0) begin fails++; $display("FAIL reset_rf_rs: got %h want 0", out_rs_data); end
    tests++; if (out_rt_data !== 32'h0) begin fails++; $display("FAIL reset_rf_rt: got %h want 0", out_rt_data); end
    tests++; if ({out_rs, out_rt, out_rd} !== {5'd7, 5'd9, 5'd1}) begin fails++; $display("FAIL fields: got %0d/%0d/%0d want 7/9/1", out_rs, out_rt, out_rd); end
  endtask

  task automatic test_bypass();
    load_instr(32'h0000_3004, {6'h00, 5'd5, 5'd0, 5'd3, 11'h021});
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
    #1;
    tests++; if (out_rs_data !== 32'h0000_1234) begin fails++; $display("FAIL bypass_same_cycle: got %h want 00001234", out_rs_data); end
    tick();
    wb_we = 1'b0;
    #1;
    tests++; if (out_rs_data !== 32'h0000_1234) begin fails++; $display("FAIL rf_stored: got %h want 00001234", out_rs_data); end
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_CAFE;
    #1;
    tests++; if (out_rs_data !== 32'h0000_CAFE) begin fails++; $display("FAIL bypass_over_stale: got %h want 0000cafe", out_rs_data); end
    tick();
    wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    #1;
    tests++; if (out_rt_data !== 32'h0) begin fails++; $display("FAIL r0_no_bypass: got %h want 0", out_rt_data); end
    tick();
    wb_we = 1'b0;
    #1;
    tests++; if (out_rt_data !== 32'h0) begin fails++; $display("FAIL r0_no_write: got %h want 0", out_rt_data); end
  endtask

  task automatic test_extension();
    logic [31:0] ins_t [8];
    logic [31:0] exp_t [8];
    ins_t = '{32'h3400_8000, 32'h2400_8000, 32'h3C00_1234, 32'h3C00_8001,
              32'h3000_FFFF, 32'h3800_8000, 32'h8C00_7FFF, 32'h1000_FFFE};
    exp_t = '{32'h0000_8000, 32'hFFFF_8000, 32'h1234_0000, 32'h8001_0000,
              32'h0000_FFFF, 32'h0000_8000, 32'h0000_7FFF, 32'hFFFF_FFFE};
    for (int i = 0; i < 8; i++) begin
      load_instr(32'h0000_3100 + 32'(i * 4), ins_t[i]);
      tests++;
      if (out_imm !== exp_t[i]) begin
        fails++; $display("FAIL imm_ext[%0d] instr %h: got %h want %h", i, ins_t[i], out_imm, exp_t[i]);
      end
    end
  endtask

  task automatic test_load_use();
    logic [31:0] ins;
    ins = {6'h00, 5'd8, 5'd9, 5'd2, 11'h021};
    load_instr(32'h0000_3200, ins);
    ex_load = 1'b1; ex_dst = 5'd8; out_ready = 1'b1;
    in_valid = 1'b1; in_pc = 32'h0000_4000; in_instr = 32'h2400_0001;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_rs_out_valid: got %0b want 0", out_valid); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready: got %0b want 0", in_ready); end
    tick();
    tests++; if (out_instr !== ins || out_pc !== 32'h0000_3200) begin fails++; $display("FAIL stall_hold: got %h@%h want %h@00003200", out_instr, out_pc, ins); end
    ex_dst = 5'd9;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_rt_out_valid: got %0b want 0", out_valid); end
    ex_load = 1'b0; ex_dst = 5'd8; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL no_load_no_stall: got %0b want 1", out_valid); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_instr !== ins) begin fails++; $display("FAIL stall_release: valid %0b instr %h want 1 %h", out_valid, out_instr, ins); end
    load_instr(32'h0000_3204, 32'h2400_0005);
    ex_load = 1'b1; ex_dst = 5'd0;
    #1;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL dst_r0_no_stall: got %0b want 1", out_valid); end
    ex_load = 1'b0;
  endtask

  task automatic test_flush();
    load_instr(32'h0000_5000, 32'h2400_00AA);
    in_valid = 1'b1; in_pc = 32'h0000_5004; in_instr = 32'h2400_00BB;
    flush = 1'b1; out_ready = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready: got %0b want 1", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_out_valid: got %0b want 0", out_valid); end
    tests++; if (out_instr === 32'h2400_00BB) begin fails++; $display("FAIL flush_incoming: got %h, flushed instr must not be held", out_instr); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_stays_empty: got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
`ifdef ID_PERF_EN
    logic [31:0] p0;
`endif
    load_instr(32'h0000_6000, 32'h2400_0060);
    in_valid = 1'b1; in_pc = 32'h0000_6004; in_instr = 32'h2400_0061; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h0000_6000 || out_instr !== 32'h2400_0060) begin
        fails++; $display("FAIL backpressure[%0d]: rdy %0b vld %0b %h@%h want 0 1 24000060@00006000", c, in_ready, out_valid, out_instr, out_pc);
      end
      tick();
    end
`ifdef ID_PERF_EN
    p0 = perf_issue;
`endif
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL backpressure_drain: got %0b want 0", out_valid); end
`ifdef ID_PERF_EN
    tests++; if (perf_issue !== p0 + 32'd1) begin fails++; $display("FAIL perf_issue_once: got %0d want %0d", perf_issue, p0 + 32'd1); end
    tick();
    tests++; if (perf_issue !== p0 + 32'd1) begin fails++; $display("FAIL perf_issue_idle: got %0d want %0d", perf_issue, p0 + 32'd1); end
`endif
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    wb_we = 1'b1; wb_addr = 5'd12; wb_data = 32'h0000_ABCD;
    tick();
    wb_we = 1'b0;
    load_instr(32'h0000_7000, {6'h00, 5'd12, 5'd0, 5'd4, 11'h021});
    tests++; if (out_rs_data !== 32'h0000_ABCD) begin fails++; $display("FAIL midop_pre: got %h want 0000abcd", out_rs_data); end
    #2;
    reset = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || out_pc !== 32'h0000_3000 || out_instr !== 32'h0) begin fails++; $display("FAIL async_reset: vld %0b %h@%h want 0 0@00003000", out_valid, out_instr, out_pc); end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    load_instr(32'h0000_7004, {6'h00, 5'd12, 5'd0, 5'd4, 11'h021});
    tests++; if (out_rs_data !== 32'h0) begin fails++; $display("FAIL async_reset_rf: got %h want 0", out_rs_data); end
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    ops = '{6'h00, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h04};
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_pc     = $urandom & 32'hFFFF_FFFC;
      in_instr  = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 31)), 11'($urandom)};
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ex_load   = ($urandom_range(0, 3) == 0);
      ex_dst    = 5'($urandom_range(0, 7));
      wb_we     = ($urandom_range(0, 1) == 1);
      wb_addr   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      #1;
      tests++; if (out_valid !== (m_valid && !m_stall())) begin fails++; $display("FAIL rnd_out_valid @%0d: got %0b want %0b", cyc, out_valid, m_valid && !m_stall()); end
      tests++; if (in_ready !== (flush || !m_valid || (out_ready && !m_stall()))) begin fails++; $display("FAIL rnd_in_ready @%0d: got %0b", cyc, in_ready); end
      tests++; if (out_pc !== m_pc || out_instr !== m_instr) begin fails++; $display("FAIL rnd_held @%0d: got %h@%h want %h@%h", cyc, out_instr, out_pc, m_instr, m_pc); end
      tests++; if ({out_rs, out_rt, out_rd} !== m_instr[25:11]) begin fails++; $display("FAIL rnd_fields @%0d: got %0d/%0d/%0d", cyc, out_rs, out_rt, out_rd); end
      tests++; if (out_rs_data !== m_read(m_instr[25:21])) begin fails++; $display("FAIL rnd_rs_data @%0d: got %h want %h", cyc, out_rs_data, m_read(m_instr[25:21])); end
      tests++; if (out_rt_data !== m_read(m_instr[20:16])) begin fails++; $display("FAIL rnd_rt_data @%0d: got %h want %h", cyc, out_rt_data, m_read(m_instr[20:16])); end
      tests++; if (out_imm !== f_imm(m_instr)) begin fails++; $display("FAIL rnd_imm @%0d: got %h want %h", cyc, out_imm, f_imm(m_instr)); end
`ifdef ID_PERF_EN
      tests++; if (perf_stall !== m_pstall || perf_issue !== m_pissue) begin fails++; $display("FAIL rnd_perf @%0d: got %0d/%0d want %0d/%0d", cyc, perf_stall, perf_issue, m_pstall, m_pissue); end
`endif
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_bypass();
    test_extension();
    test_load_use();
    test_flush();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
